seq_check_logger: RTL and testbench
===================================

Name: seq_check_logger

Overview:
- Synthesizable RTL monitor for the two-cycle handshake property "a, then b on the next clock".
- Sits alongside the DUT interface the testbench assertions watch; checks the same property in hardware so results exist in emulation/FPGA builds.
- Counts passes and failures, timestamps each failure, and queues failure records in a small FIFO drained by a valid/ready consumer such as a debug bus or trace port.

Parameters:
- CNT_W, 16, width of pass/fail counters; counters saturate.
- TS_W, 16, width of free-running cycle timestamp; wraps.
- DEPTH, 8, failure-record FIFO depth; power of two, at least 2.

Ports:
- clk, input, 1, sole clock; all sampling on posedge.
- rst, input, 1, asynchronous, active-high reset.
- en, input, 1, start a new attempt this cycle.
- a, input, 1, antecedent signal.
- b, input, 1, consequent signal.
- ovf_clr, input, 1, clears the sticky overflow flag.
- rec_ready, input, 1, consumer accepts the head record.
- rec_valid, output, 1, head record present.
- rec_start_ts, output, TS_W, timestamp of the attempt start.
- rec_fail_ts, output, TS_W, timestamp of the failure.
- rec_offend, output, 1, offending signal: 0 = a, 1 = b.
- pass_cnt, output, CNT_W, passes seen.
- fail_cnt, output, CNT_W, failures seen.
- fifo_level, output, $clog2(DEPTH)+1, number of queued records.
- overflow, output, 1, sticky flag: a record was dropped.

Behaviour:
- Reset: all outputs 0, ts=0, pending=0, FIFO empty. Reset asynchronously aborts any pending attempt; that attempt produces no record and no count.
- ts increments every clock, independent of en; wraps from 2^TS_W-1 to 0.
- Attempt states per cycle are IDLE and PEND (one pending slot is enough, since the property spans two cycles).
- Start, when en=1 at posedge with current ts=T:
  - a=0: immediate fail; record {start=T, fail=T, offend=0}.
  - a=1: latch start_ts=T; pending=1.
- Resolve, when pending=1 at posedge, regardless of en:
  - b=1: pass; pass_cnt+1.
  - b=0: fail; record {start=start_ts, fail=T, offend=1}.
  - Either way pending clears unless a new attempt re-arms it the same cycle.
- Start and resolve evaluate in the same cycle. Up to two failures per cycle.
- Push order when both fail in one cycle: the a-failure (new attempt) first, then the b-failure (old attempt).
- fail_cnt adds 0, 1 or 2 per cycle. Both counters saturate at all-ones.
- Records are visible at the FIFO output the cycle after the detecting edge (1-cycle latency).
- FIFO:
  - Supports 2 writes plus 1 read per cycle.
  - A read occurs when rec_valid && rec_ready.
  - A read frees space for same-cycle writes.
  - Writes that do not fit are dropped (the second write drops first) and set overflow=1.
  - Dropped failures still increment fail_cnt.
  - Empty FIFO: rec_valid=0; record fields hold their last values and are don't-care.
- ovf_clr clears overflow. If ovf_clr coincides with a drop, the drop wins and overflow=1.

Decomposition:
- Package seq_check_pkg:
  - typedef fail_rec_t (start_ts, fail_ts, offend).
  - localparams OFFEND_A=0 and OFFEND_B=1.
  - saturating-increment function.
- Sub-module rec_fifo2w: DEPTH-entry FIFO of fail_rec_t with two write ports, one read port, and level and drop outputs.
- Top seq_check_logger contains the timestamp counter, the pending register, the pass/fail logic and the counters.

Test Plan:
- Pass streak: after reset, a=1, b=1 and en=1 for 10 edges, then en=0 for 1 more edge -> pass_cnt=10, fail_cnt=0, rec_valid never 1.
- Immediate fail: en=1, a=0 at ts=5 (all other cycles a=1, b=1) -> one record {5, 5, offend=0}; rec_valid rises 1 cycle later; fail_cnt=1.
- Dual fail: a=1 at ts=3, then a=0, b=0 at ts=4 -> fifo_level 0->2; records in order {4, 4, 0} then {3, 4, 1}; fail_cnt=2.
- Overflow: DEPTH=8, rec_ready=0, en=1, a=0 for 12 cycles -> fifo_level=8, overflow=1, fail_cnt=12. Then rec_ready=1 -> 8 records with start_ts consecutive, drained in 8 cycles. overflow stays 1 until an ovf_clr pulse.
- Saturation and wrap: CNT_W=4, TS_W=4, 20 consecutive a=0 -> fail_cnt=15. The 17th record's start_ts wraps to the 17th-cycle ts modulo 16.
- Reset mid-pending: a=1 at ts=7, rst pulsed asynchronously before the next edge -> pending cleared, pass_cnt=0, fail_cnt=0, no record, fifo_level=0.

Source files
------------

// File: rtl/seq_check_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_check_pkg
// Description : Shared types and helpers for the "a, then b next clock"
//               hardware property checker. Failure records carry their
//               timestamps at a fixed maximum width so one record type serves
//               every timestamp width; instances zero-extend into it.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_check_pkg;

    // Widest timestamp a record can carry; TS_W of the logger must not exceed it.
    localparam int c_TS_MAX_W = 32;

    // Offending-signal codes stored in a failure record.
    localparam logic OFFEND_A = 1'b0;
    localparam logic OFFEND_B = 1'b1;

    typedef struct packed {
        logic [c_TS_MAX_W-1:0] start_ts;
        logic [c_TS_MAX_W-1:0] fail_ts;
        logic                  offend;
    } fail_rec_t;

    // Adds 0..3 to val and clamps the result at max_val (counters up to 32 bits).
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [1:0]  inc,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, val} + {31'b0, inc};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rec_fifo2w.sv
`default_nettype none
// ============================================================================
// Module      : rec_fifo2w
// Description : DEPTH-entry FIFO of failure records with two write ports and
//               one read port. A same-cycle read frees space for the writes.
//               Port 0 is always placed ahead of port 1; if space runs short,
//               port 1 is dropped first. Any dropped write pulses drop.
// Ports       : clk, rst (async, active-high)
//               wr0_en/wr0_data, wr1_en/wr1_data : write ports, 0 before 1
//               rd_ready / rd_valid / rd_data    : valid/ready head record
//               level                            : number of stored records
//               drop                             : a write was discarded
// Revision    : 1.0 - initial release
// ============================================================================
module rec_fifo2w
    import seq_check_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr0_en,
    input  fail_rec_t              wr0_data,
    input  logic                   wr1_en,
    input  fail_rec_t              wr1_data,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output fail_rec_t              rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   drop
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_DEPTH_L = (c_PTR_W + 1)'(DEPTH);

    fail_rec_t            r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_level;

    logic                 w_rd;
    logic [c_PTR_W:0]     w_space;
    logic                 w_acc0;
    logic                 w_acc1;
    logic [c_PTR_W-1:0]   w_wr_ptr1;

    always_comb begin
        w_rd      = (r_level != '0) && rd_ready;
        // Free slots after this cycle's read; never exceeds DEPTH.
        w_space   = c_DEPTH_L - r_level + (c_PTR_W + 1)'(w_rd);
        w_acc0    = wr0_en && (w_space != '0);
        w_acc1    = wr1_en && (w_space > (c_PTR_W + 1)'(w_acc0));
        // Port 1 lands right behind port 0 when both are accepted.
        w_wr_ptr1 = r_wr_ptr + c_PTR_W'(w_acc0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_acc0) begin
                r_mem[r_wr_ptr] <= wr0_data;
            end
            if (w_acc1) begin
                r_mem[w_wr_ptr1] <= wr1_data;
            end
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(w_acc0) + c_PTR_W'(w_acc1);
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(w_rd);
            r_level  <= r_level + (c_PTR_W + 1)'(w_acc0) + (c_PTR_W + 1)'(w_acc1)
                        - (c_PTR_W + 1)'(w_rd);
        end
    end

    assign rd_valid = (r_level != '0);
    assign rd_data  = r_mem[r_rd_ptr];
    assign level    = r_level;
    assign drop     = (wr0_en && !w_acc0) || (wr1_en && !w_acc1);

endmodule
`default_nettype wire

// File: rtl/seq_check_logger.sv
`default_nettype none
// ============================================================================
// Module      : seq_check_logger
// Description : Hardware checker for "a, then b on the next clock". Each en
//               pulse starts an attempt: a low fails at once, a high arms a
//               single pending slot that resolves on the next edge from b.
//               Passes and failures are counted with saturation; each failure
//               is timestamped and queued for a valid/ready consumer.
// Ports       : clk, rst (async, active-high)
//               en, a, b        : attempt start, antecedent, consequent
//               ovf_clr         : clears the sticky overflow flag
//               rec_ready/rec_valid/rec_start_ts/rec_fail_ts/rec_offend
//                               : head failure record handshake
//               pass_cnt, fail_cnt, fifo_level, overflow : status
// Revision    : 1.0 - initial release
// ============================================================================
module seq_check_logger
    import seq_check_pkg::*;
#(
    parameter int CNT_W = 16,  // up to 32
    parameter int TS_W  = 16,  // up to c_TS_MAX_W
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   a,
    input  logic                   b,
    input  logic                   ovf_clr,
    input  logic                   rec_ready,
    output logic                   rec_valid,
    output logic [TS_W-1:0]        rec_start_ts,
    output logic [TS_W-1:0]        rec_fail_ts,
    output logic                   rec_offend,
    output logic [CNT_W-1:0]       pass_cnt,
    output logic [CNT_W-1:0]       fail_cnt,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow
);

    localparam logic [0:0]       c_ST_IDLE = 1'b0;
    localparam logic [0:0]       c_ST_PEND = 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nx;
    logic [TS_W-1:0]  r_ts;
    logic [TS_W-1:0]  r_start_ts;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic             r_overflow;

    logic             w_a_fail;
    logic             w_b_fail;
    logic             w_pass;
    logic [1:0]       w_nfail;
    fail_rec_t        w_rec_a;
    fail_rec_t        w_rec_b;
    fail_rec_t        w_wr0_data;
    logic             w_wr0_en;
    logic             w_wr1_en;
    fail_rec_t        w_head;
    logic             w_drop;

    // ---------------- attempt FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // ---------------- attempt FSM: next state ----------------
    // A pending attempt always resolves this edge, so PEND only survives
    // when a fresh attempt with a=1 re-arms the slot.
    always_comb begin
        w_state_nx = c_ST_IDLE;
        if (en && a) begin
            w_state_nx = c_ST_PEND;
        end
    end

    // ---------------- attempt FSM: outputs ----------------
    always_comb begin
        w_a_fail = en && !a;
        w_pass   = (r_state == c_ST_PEND) && b;
        w_b_fail = (r_state == c_ST_PEND) && !b;
        w_nfail  = {1'b0, w_a_fail} + {1'b0, w_b_fail};

        w_rec_a          = '0;
        w_rec_a.start_ts = c_TS_MAX_W'(r_ts);
        w_rec_a.fail_ts  = c_TS_MAX_W'(r_ts);
        w_rec_a.offend   = OFFEND_A;

        w_rec_b          = '0;
        w_rec_b.start_ts = c_TS_MAX_W'(r_start_ts);
        w_rec_b.fail_ts  = c_TS_MAX_W'(r_ts);
        w_rec_b.offend   = OFFEND_B;

        // The new attempt's failure goes first; a lone b-failure takes port 0.
        w_wr0_en   = w_a_fail || w_b_fail;
        w_wr0_data = w_a_fail ? w_rec_a : w_rec_b;
        w_wr1_en   = w_a_fail && w_b_fail;
    end

    // ---------------- timestamp, start latch, counters, overflow ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts       <= '0;
            r_start_ts <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_ts <= r_ts + 1'b1;
            if (en && a) begin
                r_start_ts <= r_ts;
            end
            r_pass_cnt <= CNT_W'(sat_inc(32'(r_pass_cnt), {1'b0, w_pass}, 32'(c_CNT_MAX)));
            r_fail_cnt <= CNT_W'(sat_inc(32'(r_fail_cnt), w_nfail, 32'(c_CNT_MAX)));
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    rec_fifo2w #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr0_en   (w_wr0_en),
        .wr0_data (w_wr0_data),
        .wr1_en   (w_wr1_en),
        .wr1_data (w_rec_b),
        .rd_ready (rec_ready),
        .rd_valid (rec_valid),
        .rd_data  (w_head),
        .level    (fifo_level),
        .drop     (w_drop)
    );

    // Record timestamps are zero-extended; the upper bits are never consumed.
    generate
        if (TS_W < c_TS_MAX_W) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^{w_head.start_ts[c_TS_MAX_W-1:TS_W],
                                   w_head.fail_ts[c_TS_MAX_W-1:TS_W]};
        end
    endgenerate

    assign rec_start_ts = w_head.start_ts[TS_W-1:0];
    assign rec_fail_ts  = w_head.fail_ts[TS_W-1:0];
    assign rec_offend   = w_head.offend;
    assign pass_cnt     = r_pass_cnt;
    assign fail_cnt     = r_fail_cnt;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_seq_check_logger.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_check_logger
// Description : Self-checking bench for seq_check_logger. A behavioural model
//               advances on every driven edge and pushes expected failure
//               records into a queue; a monitor on the falling edge compares
//               status outputs and pops/compares each record the DUT hands
//               over on a valid/ready transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_check_logger;

    localparam int CNT_W   = 4;
    localparam int TS_W    = 4;
    localparam int DEPTH   = 8;
    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int TS_MOD  = 1 << TS_W;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             a = 1'b0;
    logic             b = 1'b0;
    logic             ovf_clr = 1'b0;
    logic             rec_ready = 1'b0;
    logic             rec_valid;
    logic [TS_W-1:0]  rec_start_ts;
    logic [TS_W-1:0]  rec_fail_ts;
    logic             rec_offend;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;

    always #5 clk = ~clk;

    seq_check_logger #(
        .CNT_W (CNT_W),
        .TS_W  (TS_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .a            (a),
        .b            (b),
        .ovf_clr      (ovf_clr),
        .rec_ready    (rec_ready),
        .rec_valid    (rec_valid),
        .rec_start_ts (rec_start_ts),
        .rec_fail_ts  (rec_fail_ts),
        .rec_offend   (rec_offend),
        .pass_cnt     (pass_cnt),
        .fail_cnt     (fail_cnt),
        .fifo_level   (fifo_level),
        .overflow     (overflow)
    );

    typedef struct {
        int start_ts;
        int fail_ts;
        int offend;
    } exp_rec_t;

    exp_rec_t exp_q[$];
    int m_ts, m_pend, m_start, m_level, m_pass, m_fail, m_ovf;
    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void model_reset();
        m_ts = 0; m_pend = 0; m_start = 0; m_level = 0;
        m_pass = 0; m_fail = 0; m_ovf = 0;
        exp_q.delete();
    endfunction

    // One clock edge of the property as described: start, resolve, enqueue
    // with capacity, counters with clamping.
    function automatic void model_edge();
        exp_rec_t fails[$];
        int rd, space;
        bit drop;
        drop  = 0;
        rd    = (m_level > 0 && rec_ready) ? 1 : 0;
        if (en && !a) fails.push_back('{m_ts, m_ts, 0});
        if (m_pend && !b) fails.push_back('{m_start, m_ts, 1});
        if (m_pend && b) m_pass = (m_pass + 1 > CNT_MAX) ? CNT_MAX : m_pass + 1;
        space = DEPTH - m_level + rd;
        foreach (fails[i]) begin
            if (space > 0) begin
                exp_q.push_back(fails[i]);
                space--;
                m_level++;
            end else begin
                drop = 1;
            end
        end
        m_level -= rd;
        m_fail = (m_fail + fails.size() > CNT_MAX) ? CNT_MAX : m_fail + fails.size();
        if (drop) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
        m_pend = (en && a) ? 1 : 0;
        if (en && a) m_start = m_ts;
        m_ts = (m_ts + 1) % TS_MOD;
    endfunction

    task automatic step(input bit e, input bit ia, input bit ib, input bit rdy, input bit clr);
        en = e; a = ia; b = ib; rec_ready = rdy; ovf_clr = clr;
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_pass_cnt"}, int'(pass_cnt), 0);
        chk({tag, "_fail_cnt"}, int'(fail_cnt), 0);
        chk({tag, "_level"}, int'(fifo_level), 0);
        chk({tag, "_overflow"}, int'(overflow), 0);
        chk({tag, "_rec_valid"}, int'(rec_valid), 0);
    endtask

    // Monitor: status every cycle, record contents on every transfer.
    initial begin
        exp_rec_t r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("mon_pass_cnt", int'(pass_cnt), m_pass);
                chk("mon_fail_cnt", int'(fail_cnt), m_fail);
                chk("mon_level", int'(fifo_level), m_level);
                chk("mon_overflow", int'(overflow), m_ovf);
                chk("mon_rec_valid", int'(rec_valid), (m_level > 0) ? 1 : 0);
                if (rec_valid && rec_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mon_unexpected_record actual=start %0d fail %0d offend %0d required=none",
                                 rec_start_ts, rec_fail_ts, rec_offend);
                    end else begin
                        r = exp_q.pop_front();
                        chk("rec_start_ts", int'(rec_start_ts), r.start_ts);
                        chk("rec_fail_ts", int'(rec_fail_ts), r.fail_ts);
                        chk("rec_offend", int'(rec_offend), r.offend);
                    end
                end
            end
        end
    end

    initial begin
        int budget;
        model_reset();
        #1;
        do_reset();
        chk_zero("reset");
        chk("reset_rec_start_ts", int'(rec_start_ts), 0);
        chk("reset_rec_fail_ts", int'(rec_fail_ts), 0);

        // Pass streak.
        for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("streak_pass_cnt", int'(pass_cnt), 10);
        chk("streak_fail_cnt", int'(fail_cnt), 0);

        // Immediate fail at ts=5.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        chk("imm_rec_valid", int'(rec_valid), 1);
        chk("imm_start_ts", int'(rec_start_ts), 5);
        chk("imm_offend", int'(rec_offend), 0);
        chk("imm_fail_cnt", int'(fail_cnt), 1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0);

        // Dual fail: arm at ts=3, new a-fail plus b-fail at ts=4.
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("dual_level", int'(fifo_level), 2);
        chk("dual_head_offend", int'(rec_offend), 0);
        chk("dual_head_start", int'(rec_start_ts), 4);
        chk("dual_fail_cnt", int'(fail_cnt), 2);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0);

        // Overflow, drain, sticky flag, clear.
        do_reset();
        for (int i = 0; i < 12; i++) step(1, 0, 1, 0, 0);
        chk("ovf_level", int'(fifo_level), DEPTH);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_fail_cnt", int'(fail_cnt), 12);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 1, 0);
        chk("ovf_drained", int'(fifo_level), 0);
        chk("ovf_sticky", int'(overflow), 1);
        step(0, 1, 1, 0, 1);
        chk("ovf_cleared", int'(overflow), 0);

        // Counter saturation and timestamp wrap.
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 0, 1, 1, 0);
        chk("sat_fail_cnt", int'(fail_cnt), CNT_MAX);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0);

        // Asynchronous reset while an attempt is pending.
        do_reset();
        for (int i = 0; i < 7; i++) step(0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        do_reset();
        chk_zero("midrst");
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk_zero("midrst_after");

        // Randomised traffic with ready throttling and occasional clears.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0, ((i / 40) % 2 == 0) ? ($urandom_range(0, 4) == 0)
                                                              : ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 15) == 0);
        end

        budget = 2 * DEPTH + 4;
        while (exp_q.size() != 0 && budget > 0) begin
            step(0, 1, 1, 1, 0);
            budget--;
        end
        chk("final_drain_left", exp_q.size(), 0);
        chk("final_level", int'(fifo_level), 0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
